// File: rtl/seg_scan_if.sv
// Bus bundle for the seg_scan display scanner: display-register write port,
// leading-zero control, and the registered segment/anode/frame outputs.
interface seg_scan_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        lz_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  // Host side: writes the display value, observes the scan outputs.
  modport master (
    output wr_en, wr_data, wr_dp, lz_en,
    input  seg, an, frame_done
  );

  // Scanner side.
  modport slave (
    input  wr_en, wr_data, wr_dp, lz_en,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with double-buffered display
// registers (tear-free frame commit), per-slot anti-ghost blanking and
// optional leading-zero suppression. All outputs are registered and lag
// the scan state they reflect by exactly one cycle.
module seg_scan #(
  parameter int DIV   = 50000,  // cycles per digit slot
  parameter int BLANK = 500     // blanking cycles at the start of each slot
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 4) begin : g_bad_div
    $error("seg_scan: DIV must be >= 4");
  end
  if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
    $error("seg_scan: BLANK must satisfy 1 <= BLANK < DIV");
  end

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_idx;
  logic [15:0]    r_pend_val;
  logic [3:0]     r_pend_dp;
  logic [15:0]    r_cur_val;
  logic [3:0]     r_cur_dp;
  logic [7:0]     r_seg;
  logic [3:0]     r_an;
  logic           r_frame_done;

  logic           w_wrap;
  logic           w_frame_end;
  logic [3:0]     w_nib;
  logic [6:0]     w_dec;
  logic           w_sup;

  assign w_wrap      = (r_cnt == CW'(DIV - 1));
  assign w_frame_end = w_wrap && (r_idx == 2'd3);

  // Select the committed nibble for the current digit and decide suppression.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_nib = r_cur_val[3:0];
    w_sup = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib = r_cur_val[3:0];
        w_sup = 1'b0;
      end
      2'd1: begin
        w_nib = r_cur_val[7:4];
        w_sup = bus.lz_en && (r_cur_val[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib = r_cur_val[11:8];
        w_sup = bus.lz_en && (r_cur_val[15:8] == 8'h00);
      end
      default: begin
        w_nib = r_cur_val[15:12];
        w_sup = bus.lz_en && (r_cur_val[15:12] == 4'h0);
      end
    endcase
  end

  // Hex decoder, active-low segments g..a.
  always_comb begin
    w_dec = 7'h7F;
    case (w_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h20;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      default: w_dec = 7'h0E;
    endcase
  end

  // Pending/committed display registers; commit happens on the visible
  // frame_done cycle, which always falls in a blanked slot start, so a
  // frame is never shown with mixed old/new digits.
  always_ff @(posedge clk) begin
    // NOTE: these are a handful of flops, not a memory array, so resetting them is cheap and required.
    if (rst) begin
      r_pend_val <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_cur_val  <= 16'h0000;
      r_cur_dp   <= 4'h0;
    end else begin
      if (bus.wr_en) begin
        r_pend_val <= bus.wr_data;
        r_pend_dp  <= bus.wr_dp;
      end
      if (r_frame_done) begin
        r_cur_val <= bus.wr_en ? bus.wr_data : r_pend_val;
        r_cur_dp  <= bus.wr_en ? bus.wr_dp   : r_pend_dp;
      end
    end
  end

  // Scan FSM: slot counter, digit index, blank/show state and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_an         <= 4'b1111;
      r_seg        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (r_state == ST_SHOW && !w_sup) begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= {~r_cur_dp[r_idx], w_dec};
      end else begin
        r_an  <= 4'b1111;
        r_seg <= 8'hFF;
      end

      if (w_wrap) begin
        r_cnt   <= '0;
        r_idx   <= r_idx + 2'd1;
        r_state <= ST_BLANK;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(BLANK - 1)) begin
          r_state <= ST_SHOW;
        end
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with DIV=8, BLANK=2.
// Frame positions p=1..32 follow each visible frame_done pulse: each digit
// slot is 2 blank cycles then 6 lit cycles, and p=32 carries frame_done.
module tb_seg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;
  logic prev_fd = 1'b0;

  logic [7:0] g_seg [4];
  logic       g_lit [4];

  seg_scan_if bus ();

  seg_scan #(.DIV(8), .BLANK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input logic [3:0] lit);
    g_seg[0] = s0; g_seg[1] = s1; g_seg[2] = s2; g_seg[3] = s3;
    for (int i = 0; i < 4; i++) g_lit[i] = lit[i];
  endtask

  task automatic check_cycles(input int from, input int to);
    for (int p = from; p <= to; p++) begin
      int d, off;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      step();
      d   = (p - 1) / 8;
      off = (p - 1) % 8;
      if (off < 2 || !g_lit[d]) begin
        e_an  = 4'b1111;
        e_seg = 8'hFF;
      end else begin
        e_an  = ~(4'b0001 << d);
        e_seg = g_seg[d];
      end
      check($sformatf("an_p%0d", p), 32'(bus.an), 32'(e_an));
      check($sformatf("seg_p%0d", p), 32'(bus.seg), 32'(e_seg));
      check($sformatf("fd_p%0d", p), 32'(bus.frame_done), 32'(p == 32));
    end
  endtask

  task automatic write_mid(input logic [15:0] val, input logic [3:0] dp);
    check_cycles(1, 10);
    bus.wr_en   = 1'b1;
    bus.wr_data = val;
    bus.wr_dp   = dp;
    check_cycles(11, 11);
    bus.wr_en   = 1'b0;
    check_cycles(12, 32);
  endtask

  // Invariant monitor: at most one anode low, frame_done never back-to-back.
  always @(negedge clk) begin
    if (started) begin
      check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
      check("fd_double", 32'(prev_fd && bus.frame_done), 32'd0);
      prev_fd <= bus.frame_done;
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 16'h0000;
    bus.wr_dp   = 4'h0;
    bus.lz_en   = 1'b0;
    rst         = 1'b1;

    // Reset state, with a write that must be discarded.
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hBEEF;
    bus.wr_dp   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      started = 1'b1;
      check("rst_an", 32'(bus.an), 32'h0000000F);
      check("rst_seg", 32'(bus.seg), 32'h000000FF);
      check("rst_fd", 32'(bus.frame_done), 32'd0);
    end
    bus.wr_en = 1'b0;
    rst       = 1'b0;

    // Idle: all digits show 0.
    set_all(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1111);
    check_cycles(1, 32);

    // Mid-frame write must not tear the current frame.
    write_mid(16'h12AF, 4'b0100);
    set_all(8'h8E, 8'hA0, 8'h24, 8'hF9, 4'b1111);
    check_cycles(1, 32);

    // Write on the frame_done cycle bypasses straight into the next frame.
    bus.lz_en   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h0005;
    bus.wr_dp   = 4'h0;
    set_all(8'h92, 8'hC0, 8'hC0, 8'hC0, 4'b0001);
    check_cycles(1, 1);
    bus.wr_en = 1'b0;
    check_cycles(2, 32);

    bus.lz_en = 1'b0;
    set_all(8'h92, 8'hC0, 8'hC0, 8'hC0, 4'b1111);
    check_cycles(1, 32);

    // Leading-zero suppression on 0000 and 0100.
    bus.lz_en = 1'b1;
    set_all(8'h92, 8'hC0, 8'hC0, 8'hC0, 4'b0001);
    write_mid(16'h0000, 4'h0);
    set_all(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0001);
    write_mid(16'h0100, 4'h0);
    set_all(8'hC0, 8'hC0, 8'hF9, 8'hC0, 4'b0111);

    // Reset during digit 2 SHOW with a concurrent write.
    check_cycles(1, 20);
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hFFFF;
    bus.wr_dp   = 4'hF;
    step();
    check("mid_rst_an", 32'(bus.an), 32'h0000000F);
    check("mid_rst_seg", 32'(bus.seg), 32'h000000FF);
    check("mid_rst_fd", 32'(bus.frame_done), 32'd0);
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.lz_en = 1'b0;
    set_all(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1111);
    check_cycles(1, 32);
    check_cycles(1, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot (dwell); SHALL satisfy DIV >= 4.
REQ-002 Parameter BLANK, default 500: anti-ghost blanking cycles at start of each slot; SHALL satisfy 1 <= BLANK < DIV.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port wr_en  input  1  write strobe for pending display register.
REQ-006 Port wr_data  input  16  four hex digits; [3:0] = digit 0 (rightmost).
REQ-007 Port wr_dp  input  4  decimal points; bit n = 1 lights DP of digit n.
REQ-008 Port lz_en  input  1  leading-zero suppression enable, sampled every cycle.
REQ-009 Port seg  output  8  segments, active-low; [6:0] = g..a, [7] = DP.
REQ-010 Port an  output  4  digit anodes, active-low; an[n] selects digit n.
REQ-011 Port frame_done  output  1  one-cycle pulse on last cycle of digit 3 slot.

Function
REQ-012 SHALL hold pending registers (pend_val 16b, pend_dp 4b) and committed registers (cur_val, cur_dp); display SHALL use committed only.
REQ-013 wr_en=1 SHALL load pend_val<=wr_data, pend_dp<=wr_dp on that edge; writes mid-frame SHALL NOT alter the current frame (no tearing).
REQ-014 On frame_done cycle, cur SHALL load pend on the same edge; if wr_en=1 that cycle, cur SHALL load wr_data/wr_dp directly (write bypass), and pend SHALL also take them.
REQ-015 Slot counter cnt SHALL count 0..DIV-1 then wrap to 0; digit index idx (2b) SHALL advance 0->1->2->3->0 on wrap.
REQ-016 FSM states BLANK and SHOW: BLANK while cnt < BLANK; SHOW while BLANK <= cnt <= DIV-1; BLANK->SHOW at cnt=BLANK-1 edge; SHOW->BLANK on wrap.
REQ-017 In BLANK, an SHALL be 4'b1111 and seg 8'hFF.
REQ-018 In SHOW, an SHALL be all-ones except an[idx]=0; seg[6:0] SHALL be the team hex-decoder pattern for nibble cur_val[4*idx+3:4*idx]; seg[7] SHALL be ~cur_dp[idx].
REQ-019 Decoder patterns SHALL match the existing hex segment decoder (e.g. 0->8'hC0 low 7 bits 7'h40, 8->7'h00, F->7'h0E).
REQ-020 With lz_en=1, digit n (n = 1..3) SHALL be suppressed when all nibbles n..3 of cur_val are zero; digit 0 SHALL never be suppressed.
REQ-021 Suppressed digit in SHOW SHALL drive an=4'b1111 and seg=8'hFF, including DP, regardless of cur_dp.
REQ-022 frame_done SHALL be 1 exactly when idx=3 and cnt=DIV-1, else 0.
REQ-023 Outputs an, seg, frame_done SHALL be registered; visible values SHALL lag the state/cnt they reflect by exactly one cycle, consistently for all three.
REQ-024 No two anodes SHALL ever be low in the same cycle, including across slot transitions and reset.

Reset
REQ-025 rst=1 on a clock edge SHALL set cnt=0, idx=0, state=BLANK, pend/cur val=16'h0000, pend/cur dp=4'h0.
REQ-026 Output values during and the cycle after reset SHALL be an=4'b1111, seg=8'hFF, frame_done=0.
REQ-027 rst SHALL override wr_en in the same cycle; write is discarded.
REQ-028 rst asserted mid-SHOW SHALL blank outputs on the next edge; scan SHALL restart at digit 0 BLANK after release.

Verification (DIV=8, BLANK=2)
REQ-029 Reset, then idle 40 cycles -> every SHOW phase shows seg=8'hC0, anodes rotate 1110,1101,1011,0111; 2 blank cycles precede each; frame_done period 32.
REQ-030 Write 16'h12AF, wr_dp=4'b0100, mid-frame -> current frame still shows 0s; next frame shows digit0 8'h8E, digit1 8'hA0, digit2 8'h24 (DP on), digit3 8'hF9.
REQ-031 Write 16'h0005 on the exact frame_done cycle -> following frame digit0 8'h92; with lz_en=1 digits 1-3 blanked (an=1111), with lz_en=0 show 8'hC0.
REQ-032 lz_en=1, value 16'h0000 -> only digit 0 lit with 8'hC0; value 16'h0100 -> digits 0,1,2 lit, digit 3 blanked.
REQ-033 Assert rst for 1 cycle during digit 2 SHOW with wr_en=1 -> outputs 1111/FF next cycle, cur_val=0, scan restarts at digit 0 after 2 blank cycles.
REQ-034 Assertion monitor across all tests: an never has more than one zero bit; frame_done never high two consecutive cycles.
